// File: rtl/read_return_checker.sv
// Read-return sink: pops words from an FWFT return buffer and checks each one
// against the address-derived pattern (32-bit word k == address + k).
module read_return_checker #(
  parameter int unsigned DATA_WIDTH = 128,
  parameter int unsigned ADX_WIDTH  = 27,
  parameter int unsigned HOLDOFF    = 0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable,
  input  logic                  has_return_data,
  input  logic [DATA_WIDTH-1:0] return_data,
  input  logic [ADX_WIDTH-1:0]  return_adx,
  output logic                  get_return_data,
  output logic                  busy,
  output logic [31:0]           read_count,
  output logic [15:0]           error_count,
  output logic                  error,
  output logic [ADX_WIDTH-1:0]  last_adx,
  output logic [DATA_WIDTH-1:0] last_data
);

  localparam int unsigned NUM_WORDS = DATA_WIDTH / 32;
  localparam logic [7:0]  WAIT_LOAD = (HOLDOFF > 0) ? 8'(HOLDOFF - 1) : 8'd0;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_POP,
    ST_CHECK,
    ST_WAIT
  } state_e;

  state_e                state_q, state_d;
  logic [7:0]            wait_cnt_q, wait_cnt_d;
  logic                  get_q, get_d;
  logic                  busy_q, busy_d;
  logic [31:0]           read_count_q, read_count_d;
  logic [15:0]           error_count_q, error_count_d;
  logic                  error_q, error_d;
  logic [ADX_WIDTH-1:0]  last_adx_q, last_adx_d;
  logic [DATA_WIDTH-1:0] last_data_q, last_data_d;
  logic [DATA_WIDTH-1:0] expected;
  logic                  mismatch;

  // Pattern is checked against the captured word, so the buffer is free to
  // change its head as soon as the pop has happened.
  always_comb begin
    expected = '0;
    for (int k = 0; k < NUM_WORDS; k++) begin
      expected[32*k +: 32] = 32'(last_adx_q) + 32'(k);
    end
  end

  assign mismatch = (last_data_q != expected);

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    state_d       = state_q;
    wait_cnt_d    = wait_cnt_q;
    read_count_d  = read_count_q;
    error_count_d = error_count_q;
    error_d       = error_q;
    last_adx_d    = last_adx_q;
    last_data_d   = last_data_q;

    case (state_q)
      ST_IDLE: begin
        if (has_return_data && enable) state_d = ST_POP;
      end
      ST_POP: begin
        last_data_d = return_data;
        last_adx_d  = return_adx;
        state_d     = ST_CHECK;
      end
      ST_CHECK: begin
        read_count_d = read_count_q + 32'd1;
        if (mismatch) begin
          error_d = 1'b1;
          if (error_count_q != 16'hFFFF) error_count_d = error_count_q + 16'd1;
        end
        if (HOLDOFF > 0) begin
          state_d    = ST_WAIT;
          wait_cnt_d = WAIT_LOAD;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_WAIT: begin
        if (wait_cnt_q == 8'd0) state_d = ST_IDLE;
        else                    wait_cnt_d = wait_cnt_q - 8'd1;
      end
      default: state_d = ST_IDLE;
    endcase

    // Strobe and busy are derived from the next state so they come straight off flops.
    get_d  = (state_d == ST_POP);
    busy_d = (state_d != ST_IDLE);
  end

  // NOTE: state flops use non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      wait_cnt_q    <= '0;
      get_q         <= 1'b0;
      busy_q        <= 1'b0;
      read_count_q  <= '0;
      error_count_q <= '0;
      error_q       <= 1'b0;
      last_adx_q    <= '0;
      last_data_q   <= '0;
    end else begin
      state_q       <= state_d;
      wait_cnt_q    <= wait_cnt_d;
      get_q         <= get_d;
      busy_q        <= busy_d;
      read_count_q  <= read_count_d;
      error_count_q <= error_count_d;
      error_q       <= error_d;
      last_adx_q    <= last_adx_d;
      last_data_q   <= last_data_d;
    end
  end

  assign get_return_data = get_q;
  assign busy            = busy_q;
  assign read_count      = read_count_q;
  assign error_count     = error_count_q;
  assign error           = error_q;
  assign last_adx        = last_adx_q;
  assign last_data       = last_data_q;

endmodule

// File: tb/tb_read_return_checker.sv
// Directed bench for read_return_checker: one instance with HOLDOFF=0, one with
// HOLDOFF=5, each fed from a small FWFT buffer model driven by the bench.
module tb_read_return_checker;

  typedef struct {
    logic [26:0]  adx;
    logic [127:0] data;
  } entry_t;

  logic         clk;
  logic         reset;
  logic         enable_a, enable_b;
  logic         has_a, has_b;
  logic [127:0] data_a, data_b;
  logic [26:0]  adx_a, adx_b;
  logic         get_a, get_b;
  logic         busy_a, busy_b;
  logic [31:0]  rc_a, rc_b;
  logic [15:0]  ec_a, ec_b;
  logic         err_a, err_b;
  logic [26:0]  ladx_a, ladx_b;
  logic [127:0] ldata_a, ldata_b;

  entry_t q_a[$];
  entry_t q_b[$];
  int     pops_a[$];
  int     pops_b[$];
  logic   pend_a, pend_b;
  int     cyc;
  int     checks;
  int     errors;

  read_return_checker #(.DATA_WIDTH(128), .ADX_WIDTH(27), .HOLDOFF(0)) dut_a (
    .clk(clk), .reset(reset), .enable(enable_a), .has_return_data(has_a),
    .return_data(data_a), .return_adx(adx_a), .get_return_data(get_a),
    .busy(busy_a), .read_count(rc_a), .error_count(ec_a), .error(err_a),
    .last_adx(ladx_a), .last_data(ldata_a)
  );

  read_return_checker #(.DATA_WIDTH(128), .ADX_WIDTH(27), .HOLDOFF(5)) dut_b (
    .clk(clk), .reset(reset), .enable(enable_b), .has_return_data(has_b),
    .return_data(data_b), .return_adx(adx_b), .get_return_data(get_b),
    .busy(busy_b), .read_count(rc_b), .error_count(ec_b), .error(err_b),
    .last_adx(ladx_b), .last_data(ldata_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] actual, input logic [127:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, actual, expected);
    end
  endtask

  task automatic refresh();
    has_a  = (q_a.size() > 0);
    adx_a  = has_a ? q_a[0].adx  : '0;
    data_a = has_a ? q_a[0].data : '0;
    has_b  = (q_b.size() > 0);
    adx_b  = has_b ? q_b[0].adx  : '0;
    data_b = has_b ? q_b[0].data : '0;
  endtask

  // One clock; outputs sampled 1ns after the edge. A strobe seen high means the
  // buffer pops on the following edge, so the head advances one tick later.
  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    if (pend_a && q_a.size() > 0) void'(q_a.pop_front());
    if (pend_b && q_b.size() > 0) void'(q_b.pop_front());
    pend_a = get_a;
    pend_b = get_b;
    if (get_a) pops_a.push_back(cyc);
    if (get_b) pops_b.push_back(cyc);
    refresh();
  endtask

  task automatic push(input bit to_b, input logic [26:0] adx, input logic [127:0] data);
    entry_t e;
    e.adx  = adx;
    e.data = data;
    if (to_b) q_b.push_back(e);
    else      q_a.push_back(e);
    refresh();
  endtask

  task automatic drain(input bit on_b);
    int n;
    n = 0;
    do begin
      tick();
      n++;
    end while (n < 200 && (on_b ? (q_b.size() > 0 || busy_b || pend_b)
                                : (q_a.size() > 0 || busy_a || pend_a)));
    if (n >= 200) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: got %0d cycles expected fewer than 200", n);
    end
  endtask

  initial begin
    checks   = 0;
    errors   = 0;
    cyc      = 0;
    pend_a   = 1'b0;
    pend_b   = 1'b0;
    reset    = 1'b1;
    enable_a = 1'b1;
    enable_b = 1'b1;
    refresh();

    // Reset held with a word waiting: no pop, everything zero.
    push(0, 27'h10, 128'h00000013_00000012_00000011_00000010);
    tick();
    check("rst_get_0", get_a, 0);
    tick();
    check("rst_get_1", get_a, 0);
    check("rst_busy", busy_a, 0);
    check("rst_read_count", rc_a, 0);
    check("rst_error_count", ec_a, 0);
    check("rst_error", err_a, 0);
    check("rst_last_adx", ladx_a, 0);
    check("rst_b_busy", busy_b, 0);

    // Single good word: strobe in the first cycle after reset releases.
    reset = 1'b0;
    tick();
    check("good_first_pop", get_a, 1);
    drain(0);
    check("good_pop_count", pops_a.size(), 1);
    check("good_read_count", rc_a, 1);
    check("good_error", err_a, 0);
    check("good_error_count", ec_a, 0);
    check("good_last_adx", ladx_a, 27'h10);
    check("good_last_data", ldata_a, 128'h00000013_00000012_00000011_00000010);

    // Bad word then good word: error stays sticky, count stays at one.
    push(0, 27'h20, 128'h0);
    drain(0);
    check("bad_error_count", ec_a, 1);
    check("bad_error", err_a, 1);
    check("bad_read_count", rc_a, 2);
    push(0, 27'h30, 128'h00000033_00000032_00000031_00000030);
    drain(0);
    check("sticky_error", err_a, 1);
    check("sticky_error_count", ec_a, 1);
    check("sticky_read_count", rc_a, 3);
    check("sticky_last_adx", ladx_a, 27'h30);

    // Four words back to back: strobes exactly 3 cycles apart.
    pops_a.delete();
    push(0, 27'h100,     128'h00000103_00000102_00000101_00000100);
    push(0, 27'h7FFFFFE, 128'h08000001_08000000_07FFFFFF_07FFFFFE);
    push(0, 27'h40,      128'h00000043_00000042_00000041_00000040);
    push(0, 27'h7FFFFFF, 128'h08000002_08000001_08000000_07FFFFFF);
    drain(0);
    check("b2b_pop_count", pops_a.size(), 4);
    for (int i = 1; i < 4 && i < pops_a.size(); i++) begin
      check($sformatf("b2b_gap_%0d", i), pops_a[i] - pops_a[i-1], 3);
    end
    check("b2b_read_count", rc_a, 7);
    check("b2b_error_count", ec_a, 1);
    check("b2b_last_adx", ladx_a, 27'h7FFFFFF);

    // enable low while idle: word waits, nothing pops.
    pops_a.delete();
    enable_a = 1'b0;
    push(0, 27'h200, 128'h00000203_00000202_00000201_00000200);
    for (int i = 0; i < 10; i++) tick();
    check("disabled_pops", pops_a.size(), 0);
    check("disabled_busy", busy_a, 0);
    check("disabled_read_count", rc_a, 7);
    enable_a = 1'b1;
    drain(0);
    check("enabled_read_count", rc_a, 8);

    // enable dropped after the pop: word in flight still completes.
    push(0, 27'h300, 128'h00000303_00000302_00000301_00000300);
    tick();
    check("inflight_pop", get_a, 1);
    enable_a = 1'b0;
    drain(0);
    check("inflight_read_count", rc_a, 9);
    check("inflight_last_adx", ladx_a, 27'h300);
    enable_a = 1'b1;

    // Error count saturation from a preset near the top.
    force dut_a.error_count_q = 16'hFFFD;
    #1;
    release dut_a.error_count_q;
    push(0, 27'h20, 128'h0);
    drain(0);
    check("sat_count_1", ec_a, 16'hFFFE);
    push(0, 27'h50, 128'h00000153_00000052_00000051_00000050);
    drain(0);
    check("sat_count_2", ec_a, 16'hFFFF);
    push(0, 27'h60, 128'h00000060_00000061_00000062_00000063);
    drain(0);
    check("sat_count_3", ec_a, 16'hFFFF);
    check("sat_read_count", rc_a, 12);
    check("sat_error", err_a, 1);

    // Reset during a transaction: word abandoned, counters cleared.
    push(0, 27'h400, 128'h00000403_00000402_00000401_00000400);
    tick();
    check("midrst_pop", get_a, 1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("midrst_read_count", rc_a, 0);
    check("midrst_error_count", ec_a, 0);
    check("midrst_error", err_a, 0);
    check("midrst_busy", busy_a, 0);
    check("midrst_last_adx", ladx_a, 0);
    tick();
    check("midrst_queue", q_a.size(), 0);

    // HOLDOFF=5: strobes 8 cycles apart.
    pops_b.delete();
    push(1, 27'h80, 128'h00000083_00000082_00000081_00000080);
    push(1, 27'h90, 128'h00000093_00000092_00000091_00000090);
    push(1, 27'hA0, 128'h000000A3_000000A2_000000A1_000000A0);
    drain(1);
    check("hold_pop_count", pops_b.size(), 3);
    for (int i = 1; i < 3 && i < pops_b.size(); i++) begin
      check($sformatf("hold_gap_%0d", i), pops_b[i] - pops_b[i-1], 8);
    end
    check("hold_read_count", rc_b, 3);
    check("hold_error", err_b, 0);
    check("hold_last_adx", ladx_b, 27'hA0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
